// File: rtl/ntt_pkg.sv
// Shared types and default parameters for the NTT pointwise-multiply stage.
package ntt_pkg;

  localparam int NTT_W = 32;
  localparam int NTT_N = 8;
  localparam int NTT_Q = 241;

  typedef logic [NTT_W-1:0]   coeff_t;
  typedef logic [2*NTT_W-1:0] prod_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    HAVE_A = 1'b1
  } state_t;

endpackage

// File: rtl/mod_mult_pipe.sv
// One lane of the pointwise multiplier: registered exact product, then registered
// reduction modulo Modulus_Q, with a valid flag travelling alongside.
module mod_mult_pipe
  import ntt_pkg::*;
#(
  parameter int           W         = NTT_W,
  parameter logic [W-1:0] Modulus_Q = W'(NTT_Q)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         valid_out,
  output logic [W-1:0] result
);

  localparam logic [2*W-1:0] Q_WIDE = {{W{1'b0}}, Modulus_Q};

  logic [2*W-1:0] prod_reg;
  logic           s1_valid_reg;
  logic [W-1:0]   result_reg;
  logic           s2_valid_reg;
  logic [W-1:0]   remainder;

  // The remainder is always below Modulus_Q < 2**W, so truncation loses nothing.
  assign remainder = W'(prod_reg % Q_WIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_reg     <= '0;
      s1_valid_reg <= 1'b0;
      result_reg   <= '0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= valid_in;
      s2_valid_reg <= s1_valid_reg;
      if (valid_in) begin
        prod_reg <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
      end
      if (s1_valid_reg) begin
        result_reg <= remainder;
      end
    end
  end

  assign valid_out = s2_valid_reg;
  assign result    = result_reg;

endmodule

// File: rtl/ntt_pointwise_mult.sv
// Pairs consecutive forward-NTT vectors as A then B and emits C[i] = A[i]*B[i] mod Q,
// tagged for the inverse pass, three register stages after B is taken.
module ntt_pointwise_mult
  import ntt_pkg::*;
#(
  parameter int           W         = NTT_W,
  parameter int           N         = NTT_N,
  parameter logic [W-1:0] Modulus_Q = W'(NTT_Q)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         mode_in,
  input  logic [W-1:0] Data_in  [0:N-1],
  output logic [W-1:0] Data_out [0:N-1],
  output logic         data_valid_out,
  output logic         mode_out,
  output logic         a_pending
);

  state_t       state_reg;
  logic [W-1:0] a_buf_reg    [0:N-1];
  logic [W-1:0] data_out_reg [0:N-1];
  logic [W-1:0] lane_result  [0:N-1];
  logic [N-1:0] lane_valid;
  logic         data_valid_out_reg;
  logic         mode_out_reg;
  logic         accept;
  logic         launch;

  // iNTT results arriving on the shared bus are not ours to pair.
  assign accept = data_valid_in && !mode_in;
  assign launch = accept && (state_reg == HAVE_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (accept) begin
      state_reg <= (state_reg == IDLE) ? HAVE_A : IDLE;
    end
  end

  // The buffer needs no reset: a stale A is unreachable once the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (accept && (state_reg == IDLE)) begin
      a_buf_reg <= Data_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      mod_mult_pipe #(
        .W         (W),
        .Modulus_Q (Modulus_Q)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (launch),
        .a         (a_buf_reg[gi]),
        .b         (Data_in[gi]),
        .valid_out (lane_valid[gi]),
        .result    (lane_result[gi])
      );
    end
  endgenerate

  // All lanes share one launch strobe, so their valid flags always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid_out_reg <= 1'b0;
      mode_out_reg       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        data_out_reg[i] <= '0;
      end
    end else begin
      data_valid_out_reg <= &lane_valid;
      mode_out_reg       <= &lane_valid;
      if (&lane_valid) begin
        data_out_reg <= lane_result;
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign Data_out[gi] = data_out_reg[gi];
    end
  endgenerate

  assign data_valid_out = data_valid_out_reg;
  assign mode_out       = mode_out_reg;
  assign a_pending      = (state_reg == HAVE_A);

endmodule

// File: tb/tb_ntt_pointwise_mult.sv
// Directed bench for ntt_pointwise_mult: a vector table of A/B/C triples plus
// hand-written sequences for back-to-back, ignored-mode and reset corner cases.
module tb_ntt_pointwise_mult;

  localparam int W = 32;
  localparam int N = 8;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t a;
    vec_t b;
    vec_t c;
  } pair_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid_in = 1'b0;
  logic         mode_in = 1'b0;
  logic [W-1:0] data_in  [0:N-1];
  logic [W-1:0] data_out [0:N-1];
  logic         data_valid_out;
  logic         mode_out;
  logic         a_pending;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  ntt_pointwise_mult dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid_in  (data_valid_in),
    .mode_in        (mode_in),
    .Data_in        (data_in),
    .Data_out       (data_out),
    .data_valid_out (data_valid_out),
    .mode_out       (mode_out),
    .a_pending      (a_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && data_valid_out) pulse_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t fill(input int x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(x);
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid, input logic mode);
    for (int i = 0; i < N; i++) data_in[i] = v[i];
    data_valid_in = valid;
    mode_in = mode;
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_vec(input string name, input vec_t expected);
    int bad = -1;
    checks++;
    for (int i = N - 1; i >= 0; i--) begin
      if (data_out[i] !== expected[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %0d expected %0d", name, bad, data_out[bad], expected[bad]);
    end
  endtask

  // A then B on consecutive cycles; the pulse must land exactly two edges after B's edge.
  task automatic run_pair(input string name, input pair_t p);
    drive(p.a, 1'b1, 1'b0);
    step();
    check_bit({name, " a_pending after A"}, a_pending, 1'b1);
    drive(p.b, 1'b1, 1'b0);
    step();
    drive(fill(0), 1'b0, 1'b0);
    check_bit({name, " a_pending after B"}, a_pending, 1'b0);
    check_bit({name, " valid at B+1"}, data_valid_out, 1'b0);
    step();
    check_bit({name, " valid at B+1 edge"}, data_valid_out, 1'b0);
    step();
    check_bit({name, " valid at B+2"}, data_valid_out, 1'b1);
    check_bit({name, " mode at B+2"}, mode_out, 1'b1);
    check_vec({name, " data"}, p.c);
    step();
    check_bit({name, " valid after pulse"}, data_valid_out, 1'b0);
    check_bit({name, " mode after pulse"}, mode_out, 1'b0);
    check_vec({name, " data held"}, p.c);
    $display("txn %s done", name);
  endtask

  pair_t table_v [4];
  vec_t  v_inc, v_dec, v_res;
  int    pulses_before;

  initial begin
    for (int i = 0; i < N; i++) data_in[i] = '0;

    for (int i = 0; i < N; i++) begin
      v_inc[i] = W'(i + 1);
      v_dec[i] = W'(N - i);
      v_res[i] = W'((i + 1) * (N - i));
    end
    table_v[0] = '{a: fill(2),   b: fill(3),   c: fill(6)};
    table_v[1] = '{a: fill(240), b: fill(240), c: fill(1)};
    table_v[2] = '{a: v_inc,     b: v_dec,     c: v_res};
    table_v[3] = '{a: fill(100), b: fill(200), c: fill(238)};

    repeat (3) step();
    reset = 1'b0;
    check_bit("reset valid", data_valid_out, 1'b0);
    check_bit("reset mode", mode_out, 1'b0);
    check_bit("reset a_pending", a_pending, 1'b0);
    check_vec("reset data", fill(0));
    step();

    for (int t = 0; t < 4; t++) begin
      run_pair($sformatf("vec%0d", t), table_v[t]);
    end

    // Four back-to-back beats pair as (P0,P1),(P2,P3).
    pulses_before = pulse_count;
    drive(fill(2), 1'b1, 1'b0);  step(); check_bit("b2b pend0", a_pending, 1'b1);
    drive(fill(5), 1'b1, 1'b0);  step(); check_bit("b2b pend1", a_pending, 1'b0);
    check_bit("b2b e1 valid", data_valid_out, 1'b0);
    drive(fill(7), 1'b1, 1'b0);  step(); check_bit("b2b pend2", a_pending, 1'b1);
    check_bit("b2b e2 valid", data_valid_out, 1'b0);
    drive(fill(40), 1'b1, 1'b0); step(); check_bit("b2b pend3", a_pending, 1'b0);
    drive(fill(0), 1'b0, 1'b0);
    check_bit("b2b e3 valid", data_valid_out, 1'b1);
    check_vec("b2b first", fill(10));
    step(); check_bit("b2b e4 valid", data_valid_out, 1'b0);
    step(); check_bit("b2b e5 valid", data_valid_out, 1'b1);
    check_vec("b2b second", fill(39));
    step(); check_bit("b2b e6 valid", data_valid_out, 1'b0);
    step(); step();
    check_int("b2b pulse count", pulse_count - pulses_before, 2);
    $display("txn back_to_back done");

    // A mode_in=1 beat between A and B is ignored.
    drive(fill(3), 1'b1, 1'b0); step();
    drive(fill(9), 1'b1, 1'b1); step();
    check_bit("ignore pend", a_pending, 1'b1);
    check_bit("ignore no out", data_valid_out, 1'b0);
    drive(fill(4), 1'b1, 1'b0); step();
    drive(fill(0), 1'b0, 1'b0);
    check_bit("ignore pend after B", a_pending, 1'b0);
    step(); check_bit("ignore B+1", data_valid_out, 1'b0);
    step(); check_bit("ignore B+2", data_valid_out, 1'b1);
    check_vec("ignore data", fill(12));
    step();
    $display("txn ignore_mode done");

    // Reset while A is buffered discards A.
    pulses_before = pulse_count;
    drive(fill(6), 1'b1, 1'b0); step();
    drive(fill(0), 1'b0, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check_bit("rst a_pending", a_pending, 1'b0);
    check_vec("rst clears data", fill(0));
    drive(fill(10), 1'b1, 1'b0); step();
    check_bit("rst X pend", a_pending, 1'b1);
    drive(fill(11), 1'b1, 1'b0); step();
    drive(fill(0), 1'b0, 1'b0);
    step(); step();
    check_bit("rst XY valid", data_valid_out, 1'b1);
    check_vec("rst XY data", fill(110 % 241));
    step(); step();
    check_int("rst pulse count", pulse_count - pulses_before, 1);
    $display("txn reset_a done");

    // Reset while the pair sits in S1 suppresses its pulse.
    pulses_before = pulse_count;
    drive(fill(2), 1'b1, 1'b0); step();
    drive(fill(2), 1'b1, 1'b0); step();
    drive(fill(0), 1'b0, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    step(); check_bit("rst S1 no pulse", data_valid_out, 1'b0);
    step(); step();
    check_int("rst S1 pulse count", pulse_count - pulses_before, 0);
    check_vec("rst S1 data", fill(0));
    $display("txn reset_s1 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
